// File: rtl/command_entry_ctrl.sv
// Command entry controller: assembles {address[4:0], command[6:0]} one hex digit
// at a time, drives cursor blanking, and submits the word over valid/ready.
module command_entry_ctrl #(
  parameter int BLINK_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  input  logic        key_back,
  input  logic        key_enter,
  input  logic        key_clear,
  output logic [11:0] cmd_buf,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  digit_pos,
  output logic [3:0]  digit_blank,
  output logic        busy,
  output logic        err
);

  typedef enum logic [0:0] {
    ST_EDIT    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           count_q, count_d;
  logic [11:0]          buf_q, buf_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [3:0]           blank_q, blank_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;

  // Field layout: pos0=addr[4] (bit 11), pos1=addr[3:0], pos2=cmd[6:4], pos3=cmd[3:0].
  function automatic logic [11:0] set_field(input logic [11:0] w,
                                            input logic [2:0]  pos,
                                            input logic [3:0]  v);
    logic [11:0] r;
    r = w;
    case (pos)
      3'd0:    r[11]   = v[0];
      3'd1:    r[10:7] = v;
      3'd2:    r[6:4]  = v[2:0];
      default: r[3:0]  = v;
    endcase
    return r;
  endfunction

  function automatic logic digit_in_range(input logic [2:0] pos,
                                          input logic [3:0] v);
    logic ok;
    case (pos)
      3'd0:    ok = (v <= 4'd1);
      3'd2:    ok = (v <= 4'd7);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    blink_d = blink_q + 1'b1;

    case (state_q)
      ST_EDIT: begin
        if (key_clear) begin
          buf_d   = 12'h000;
          count_d = 3'd0;
        end else if (key_enter) begin
          if (count_q == 3'd4) begin
            state_d = ST_PENDING;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_back) begin
          if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
            buf_d   = set_field(buf_q, count_q - 3'd1, 4'd0);
          end
        end else if (key_valid) begin
          if (count_q == 3'd4 || !digit_in_range(count_q, key_data)) begin
            err_d = 1'b1;
          end else begin
            // First digit of a new entry replaces the previously shown word.
            buf_d   = set_field((count_q == 3'd0) ? 12'h000 : buf_q, count_q, key_data);
            count_d = count_q + 3'd1;
          end
        end
      end

      ST_PENDING: begin
        if (cmd_ready) begin
          state_d = ST_EDIT;
          valid_d = 1'b0;
          count_d = 3'd0;
        end else if (key_clear) begin
          state_d = ST_EDIT;
          valid_d = 1'b0;
          count_d = 3'd0;
          buf_d   = 12'h000;
        end
        // An effective abort swallows the other keys of that cycle silently.
        if ((key_valid || key_back || key_enter) && !(key_clear && !cmd_ready)) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_EDIT;
      end
    endcase

    if (state_d == ST_EDIT && count_d < 3'd4) begin
      blank_d = 4'(blink_d[BLINK_W-1]) << count_d[1:0];
    end else begin
      blank_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EDIT;
      count_q <= 3'd0;
      buf_q   <= 12'h000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 4'b0000;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
    end
  end

  assign cmd_buf     = buf_q;
  assign cmd_valid   = valid_q;
  assign digit_pos   = count_q;
  assign digit_blank = blank_q;
  assign busy        = (state_q == ST_PENDING);
  assign err         = err_q;

endmodule

// File: tb/tb_command_entry_ctrl.sv
// Bench for command_entry_ctrl: field-level reference model compared every cycle,
// plus directed key sequences with literal expected values.
module tb_command_entry_ctrl;

  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_data = 4'd0;
  logic        key_back = 1'b0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [11:0] cmd_buf;
  logic        cmd_valid;
  logic [2:0]  digit_pos;
  logic [3:0]  digit_blank;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  command_entry_ctrl #(.BLINK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_data(key_data), .key_back(key_back),
    .key_enter(key_enter), .key_clear(key_clear),
    .cmd_buf(cmd_buf), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .digit_pos(digit_pos), .digit_blank(digit_blank), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: four digit fields, an entry count, a pending flag, edge count.
  logic [3:0] fld[4];
  int         m_n;
  bit         m_pend;
  bit         m_err;
  int         m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fld[i] = 4'd0;
      m_n = 0; m_pend = 0; m_err = 0; m_edges = 0;
    end else begin
      int lim;
      m_edges++;
      m_err = 0;
      if (!m_pend) begin
        if (key_clear) begin
          for (int i = 0; i < 4; i++) fld[i] = 4'd0;
          m_n = 0;
        end else if (key_enter) begin
          if (m_n == 4) m_pend = 1; else m_err = 1;
        end else if (key_back) begin
          if (m_n > 0) begin m_n--; fld[m_n] = 4'd0; end
        end else if (key_valid) begin
          lim = (m_n == 0) ? 1 : (m_n == 2) ? 7 : 15;
          if (m_n == 4 || int'(key_data) > lim) m_err = 1;
          else begin
            if (m_n == 0) for (int i = 0; i < 4; i++) fld[i] = 4'd0;
            fld[m_n] = key_data;
            m_n++;
          end
        end
      end else begin
        if (cmd_ready) begin m_pend = 0; m_n = 0; end
        else if (key_clear) begin
          m_pend = 0; m_n = 0;
          for (int i = 0; i < 4; i++) fld[i] = 4'd0;
        end
        if ((key_valid || key_back || key_enter) && !(key_clear && !cmd_ready)) m_err = 1;
      end
    end
  end

  function automatic logic [11:0] model_word();
    return {fld[0][0], fld[1], fld[2][2:0], fld[3]};
  endfunction

  function automatic logic [3:0] model_blank();
    if (!m_pend && m_n < 4 && ((m_edges >> (BW - 1)) & 1) == 1) return 4'b0001 << m_n;
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cmd_buf", cmd_buf, model_word());
      chk("m_cmd_valid", cmd_valid, m_pend);
      chk("m_busy", busy, m_pend);
      chk("m_digit_pos", digit_pos, m_n);
      chk("m_err", err, m_err);
      chk("m_digit_blank", digit_blank, model_blank());
    end
  end

  // Apply one cycle of inputs (called just after a falling edge), return just after the next one.
  task automatic cyc(input logic v, input logic [3:0] d, input logic b,
                     input logic e, input logic c, input logic r);
    key_valid = v; key_data = d; key_back = b; key_enter = e; key_clear = c; cmd_ready = r;
    @(negedge clk); #1;
    key_valid = 0; key_back = 0; key_enter = 0; key_clear = 0; cmd_ready = 0;
  endtask

  task automatic key(input logic [3:0] d); cyc(1, d, 0, 0, 0, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

  int n_on, n_off, n_other;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rst_cmd_buf", cmd_buf, 12'h000);
    chk("rst_digit_pos", digit_pos, 3'd0);

    // Full entry and handshake.
    key(4'h1); key(4'hF); key(4'h7); key(4'hA);
    chk("full_buf", cmd_buf, 12'hFFA);
    chk("full_pos", digit_pos, 3'd4);
    cyc(0, 0, 0, 1, 0, 0);
    chk("enter_valid", cmd_valid, 1'b1);
    chk("enter_busy", busy, 1'b1);
    idle();
    cyc(1, 4'h3, 0, 0, 0, 0);
    chk("pend_key_err", err, 1'b1);
    chk("pend_key_buf", cmd_buf, 12'hFFA);
    idle();
    chk("hold_valid", cmd_valid, 1'b1);
    chk("hold_buf", cmd_buf, 12'hFFA);
    cyc(0, 0, 0, 0, 0, 1);
    chk("hs_valid", cmd_valid, 1'b0);
    chk("hs_pos", digit_pos, 3'd0);
    chk("hs_buf", cmd_buf, 12'hFFA);

    // Range errors.
    key(4'h2);
    chk("rng0_err", err, 1'b1);
    chk("rng0_pos", digit_pos, 3'd0);
    idle();
    chk("err_pulse", err, 1'b0);
    key(4'h0); key(4'h3); key(4'h9);
    chk("rng2_err", err, 1'b1);
    chk("rng2_buf", cmd_buf, 12'h180);

    // Backspace.
    cyc(0, 0, 0, 0, 1, 0);
    key(4'h1); key(4'h2); key(4'h3);
    chk("three_buf", cmd_buf, 12'h930);
    cyc(0, 0, 1, 0, 0, 0);
    chk("back_pos", digit_pos, 3'd2);
    chk("back_buf", cmd_buf, 12'h900);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    chk("back2_buf", cmd_buf, 12'h000);
    cyc(0, 0, 1, 0, 0, 0);
    chk("back0_err", err, 1'b0);
    chk("back0_pos", digit_pos, 3'd0);

    // Early enter and overflow.
    key(4'h1); key(4'h2); key(4'h3);
    cyc(0, 0, 0, 1, 0, 0);
    chk("early_enter_err", err, 1'b1);
    chk("early_enter_busy", busy, 1'b0);
    key(4'h4);
    chk("four_buf", cmd_buf, 12'h934);
    key(4'h5);
    chk("ovf_err", err, 1'b1);
    chk("ovf_buf", cmd_buf, 12'h934);

    // Simultaneous events.
    cyc(0, 0, 0, 0, 1, 0);
    key(4'h1); key(4'h2);
    cyc(1, 4'h1, 0, 0, 1, 0);
    chk("clr_dig_buf", cmd_buf, 12'h000);
    chk("clr_dig_pos", digit_pos, 3'd0);
    chk("clr_dig_err", err, 1'b0);
    key(4'h1); key(4'hF); key(4'h7); key(4'hA);
    cyc(0, 0, 1, 1, 0, 0);
    chk("ent_back_busy", busy, 1'b1);
    chk("ent_back_pos", digit_pos, 3'd4);

    // Abort from PENDING.
    cyc(0, 0, 0, 0, 1, 0);
    chk("abort_valid", cmd_valid, 1'b0);
    chk("abort_buf", cmd_buf, 12'h000);

    // Cursor blink at count=1.
    key(4'h1);
    n_on = 0; n_off = 0; n_other = 0;
    for (int i = 0; i < 16; i++) begin
      if (digit_blank == 4'b0010) n_on++;
      else if (digit_blank == 4'b0000) n_off++;
      else n_other++;
      idle();
    end
    chk("blink_on", n_on, 8);
    chk("blink_off", n_off, 8);
    chk("blink_other", n_other, 0);

    // Reset in PENDING.
    key(4'h2); key(4'h3); key(4'h4);
    cyc(0, 0, 0, 1, 0, 0);
    chk("pre_rst_valid", cmd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", cmd_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_buf", cmd_buf, 12'h000);
    chk("async_rst_pos", digit_pos, 3'd0);
    chk("async_rst_blank", digit_blank, 4'b0000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(); idle();
    chk("post_rst_valid", cmd_valid, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/command_entry_ctrl.md
Name: command_entry_ctrl

Overview:
- Assembles the 12-bit command word {address[4:0], command[6:0]} one hex digit at a time from debounced key events.
- Drives the 4-digit command display with cursor blanking, then hands the finished word to the execution side over a valid/ready handshake.
- Sits between the keypad debouncer and the command executor; its cmd_buf output also feeds the 7-segment command display.

Parameters:
BLINK_W, 24, width of the free-running blink counter; cursor phase = counter MSB (period 2^BLINK_W clk cycles).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle pulse: hex digit key pressed
key_data  input  4  hex digit value, sampled when key_valid=1
key_back  input  1  one-cycle pulse: delete last digit
key_enter  input  1  one-cycle pulse: submit command
key_clear  input  1  one-cycle pulse: discard entry
cmd_buf  output  12  {address[4:0], command[6:0]} being edited or submitted
cmd_valid  output  1  submitted command available
cmd_ready  input  1  executor accepts command
digit_pos  output  3  number of digits entered, 0..4
digit_blank  output  4  per-display blank enable; bit0=address high ... bit3=command low
busy  output  1  1 while in PENDING
err  output  1  one-cycle pulse: key rejected

Behaviour:
- Reset (async, rst_n=0):
  - state=EDIT, count=0, cmd_buf=0, cmd_valid=0, busy=0, err=0, blink counter=0, digit_blank=0.
- All outputs registered. A key event in cycle N is reflected in outputs at N+1.
- Digit positions and ranges:
  - pos0 = address[4], valid value 0..1.
  - pos1 = address[3:0], valid value 0..F.
  - pos2 = command[6:4], valid value 0..7.
  - pos3 = command[3:0], valid value 0..F.
- EDIT state:
  - key_valid, count<4, value in range: write field at pos=count, count+1. If count==0, first clear all other fields to 0 (replaces previously submitted word).
  - key_valid with count==4, or value out of range: no change, err=1.
  - key_back: if count>0, count-1 and field at new count cleared to 0. At count==0 it is a no-op with no err.
  - key_enter: if count==4, go to PENDING and set cmd_valid=1, busy=1. Otherwise err=1.
  - key_clear: cmd_buf=0, count=0, no err.
- Simultaneous events in one cycle: priority clear > enter > back > digit. Lower-priority events in that cycle are dropped silently (no err).
- PENDING state:
  - cmd_buf held stable; cmd_valid held at 1 until handshake.
  - Handshake when cmd_valid&&cmd_ready in a cycle. Next cycle: cmd_valid=0, busy=0, state=EDIT, count=0. cmd_buf keeps the submitted word for display.
  - key_valid, key_back or key_enter while PENDING: ignored, err=1.
  - key_clear while PENDING: abort. cmd_valid=0, state=EDIT, cmd_buf=0, count=0. If cmd_ready is high in the same cycle, the handshake wins and clear is ignored.
- Blink counter:
  - Free-running, wraps at 2^BLINK_W.
  - In EDIT with count<4: digit_blank[count] = counter MSB; all other bits 0.
  - Otherwise (count==4 or PENDING): digit_blank=0.
- digit_pos equals count.
- err is a single-cycle pulse only, never sticky.
- Reset asserted mid-PENDING: cmd_valid drops immediately (async), no handshake completes.

Test Plan:
- Reset, then keys 1,F,7,A, then enter -> cmd_buf=12'hFFA, digit_pos=4, then cmd_valid=1, busy=1. Hold cmd_ready=0 for 3 cycles -> cmd_buf/cmd_valid stable. Raise cmd_ready -> next cycle cmd_valid=0, digit_pos=0, cmd_buf still 12'hFFA.
- From count=0, key 2 -> err pulse 1 cycle, digit_pos=0. Keys 0,3, then key 9 at pos2 -> err, cmd_buf=12'h180 unchanged.
- Keys 1,2,3, back -> digit_pos=2, cmd_buf=12'h900. Back×2 -> 12'h000. Back again -> no change, no err.
- Enter at count=3 -> err, stays EDIT. Digit when full (count=4) -> err, cmd_buf unchanged.
- Same cycle key_clear + key_valid(1) at count=2 -> cmd_buf=0, count=0, no err. Same cycle key_enter + key_back at count=4 -> PENDING, count stays 4.
- BLINK_W=4: at count=1, digit_blank toggles between 4'b0010 and 4'b0000 every 8 cycles. In PENDING, pulse rst_n low -> cmd_valid=0 before the next clk edge, all outputs at reset values.
